// File: rtl/stuf_pkg.sv
// Shared defaults and helpers for the stuf bit-stuffing encoder.
package stuf_pkg;

  localparam int unsigned StuffLenDefault = 5;
  localparam int unsigned DepthDefault    = 16;

  // Pointer width: one extra MSB distinguishes full from empty.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  typedef enum logic [1:0] {
    ActIdle,
    ActStuff,
    ActPass
  } act_e;

endpackage

// File: rtl/stuf_fifo.sv
// 1-bit-wide synchronous FIFO with async active-high reset; overflowing pushes are dropped.
module stuf_fifo
  import stuf_pkg::*;
#(
  parameter int unsigned DEPTH = DepthDefault
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  logic data_i,
  input  logic pop_i,
  output logic data_o,
  output logic empty_o
);

  localparam int unsigned PtrW  = ptr_width(DEPTH);
  localparam int unsigned AddrW = PtrW - 1;

  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [DEPTH-1:0] mem_q, mem_d;
  logic             full;
  logic             push_ok;
  logic             pop_ok;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[PtrW-1] != rd_ptr_q[PtrW-1]) &&
                   (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign pop_ok  = pop_i && !empty_o;
  // A full FIFO still takes a push when a pop frees a slot in the same cycle.
  assign push_ok = push_i && (!full || pop_ok);
  assign data_o  = mem_q[rd_ptr_q[AddrW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q[AddrW-1:0]] = data_i;
      wr_ptr_d                   = wr_ptr_q + PtrW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/stuf.sv
// HDLC-style bit-stuffing encoder: inserts a 0 after every STUFF_LEN consecutive 1s.
// Define STUF_IDLE_CLEAR_EN to restart the run count on every idle output cycle.
module stuf
  import stuf_pkg::*;
#(
  parameter int unsigned STUFF_LEN = StuffLenDefault,
  parameter int unsigned DEPTH     = DepthDefault
) (
  input  logic clk,
  input  logic rst,
  input  logic valid_in,
  input  logic data_in,
  output logic valid_stuffed,
  output logic stuffed_data
);

  localparam int unsigned CntW = $clog2(STUFF_LEN + 1);

  logic [CntW-1:0] ones_q, ones_d;
  logic            valid_q, valid_d;
  logic            data_q, data_d;
  logic            fifo_data;
  logic            fifo_empty;
  logic            pop;
  act_e            act;

  stuf_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (valid_in),
    .data_i  (data_in),
    .pop_i   (pop),
    .data_o  (fifo_data),
    .empty_o (fifo_empty)
  );

  // A pending stuff takes priority over draining the backlog.
  always_comb begin
    act = ActIdle;
    if (ones_q == CntW'(STUFF_LEN)) begin
      act = ActStuff;
    end else if (!fifo_empty) begin
      act = ActPass;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ones_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= 1'b0;
    end else begin
      ones_q  <= ones_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    ones_d = ones_q;
    unique case (act)
      ActStuff: ones_d = '0;
      ActPass:  ones_d = fifo_data ? ones_q + CntW'(1) : '0;
      ActIdle: begin
`ifdef STUF_IDLE_CLEAR_EN
        ones_d = '0;
`else
        ones_d = ones_q;
`endif
      end
      default:  ones_d = ones_q;
    endcase
  end

  always_comb begin
    valid_d = 1'b0;
    data_d  = 1'b0;
    pop     = 1'b0;
    unique case (act)
      ActStuff: valid_d = 1'b1;
      ActPass: begin
        valid_d = 1'b1;
        data_d  = fifo_data;
        pop     = 1'b1;
      end
      default: begin
        valid_d = 1'b0;
        data_d  = 1'b0;
      end
    endcase
  end

  assign valid_stuffed = valid_q;
  assign stuffed_data  = data_q;

endmodule

// File: tb/tb_stuf.sv
// Scoreboard bench for stuf: one DEPTH=16 and one DEPTH=4 instance fed the same stream.
module tb_stuf;

  typedef struct {
    logic        b;
    int unsigned cyc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        valid_in;
  logic        data_in;
  logic        va, da, vb, db;
  int unsigned cyc = 0;
  int          n_vec = 0;
  int          n_fail = 0;
  string       tname = "reset";
  exp_t        qa[$];
  exp_t        qb[$];

  stuf #(
    .STUFF_LEN (5),
    .DEPTH     (16)
  ) u_dut_a (
    .clk           (clk),
    .rst           (rst),
    .valid_in      (valid_in),
    .data_in       (data_in),
    .valid_stuffed (va),
    .stuffed_data  (da)
  );

  stuf #(
    .STUFF_LEN (5),
    .DEPTH     (4)
  ) u_dut_b (
    .clk           (clk),
    .rst           (rst),
    .valid_in      (valid_in),
    .data_in       (data_in),
    .valid_stuffed (vb),
    .stuffed_data  (db)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_bit(input string what, input logic got, input logic req);
    n_vec++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s %s: got %b, required %b", tname, what, got, req);
    end
  endtask

  function automatic string rep(input string s, input int n);
    string r = "";
    for (int i = 0; i < n; i++) r = {r, s};
    return r;
  endfunction

  // Monitor: pops one expected bit per valid output and checks value and cycle.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst) begin
      if (va === 1'b1) begin
        n_vec++;
        if (qa.size() == 0) begin
          n_fail++;
          $display("FAIL %s dut16 unexpected valid at cycle %0d: got bit %b, required none",
                   tname, cyc, da);
        end else begin
          e = qa.pop_front();
          if (da !== e.b || cyc != e.cyc) begin
            n_fail++;
            $display("FAIL %s dut16 output: got %b at cycle %0d, required %b at cycle %0d",
                     tname, da, cyc, e.b, e.cyc);
          end
        end
      end else begin
        check_bit("dut16 idle valid/data", va | da, 1'b0);
      end
      if (vb === 1'b1) begin
        n_vec++;
        if (qb.size() == 0) begin
          n_fail++;
          $display("FAIL %s dut4 unexpected valid at cycle %0d: got bit %b, required none",
                   tname, cyc, db);
        end else begin
          e = qb.pop_front();
          if (db !== e.b || cyc != e.cyc) begin
            n_fail++;
            $display("FAIL %s dut4 output: got %b at cycle %0d, required %b at cycle %0d",
                     tname, db, cyc, e.b, e.cyc);
          end
        end
      end else begin
        check_bit("dut4 idle valid/data", vb | db, 1'b0);
      end
    end
  end

  // Drives one burst and queues the expected output of each DUT, back to back from
  // two cycles after the first drive point (sampled at the next edge, registered one later).
  task automatic run_vec(input string din, input string exp_a, input string exp_b);
    int unsigned base;
    @(posedge clk); #1;
    base = cyc;
    for (int j = 0; j < exp_a.len(); j++) qa.push_back('{exp_a[j] == "1", base + 2 + j});
    for (int j = 0; j < exp_b.len(); j++) qb.push_back('{exp_b[j] == "1", base + 2 + j});
    for (int i = 0; i < din.len(); i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      valid_in = 1'b1;
      data_in  = (din[i] == "1");
    end
    @(posedge clk); #1;
    valid_in = 1'b0;
    data_in  = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (qa.size() != 0 || qb.size() != 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL %s drain timeout: %0d/%0d bits still missing, required 0/0",
               tname, qa.size(), qb.size());
      qa.delete();
      qb.delete();
    end
    repeat (4) @(posedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    string exp5;
    rst      = 1'b1;
    valid_in = 1'b0;
    data_in  = 1'b0;

    // Reset held one cycle, then idle with no input.
    @(posedge clk); #1;
    check_bit("dut16 valid after reset", va, 1'b0);
    check_bit("dut16 data after reset", da, 1'b0);
    check_bit("dut4 valid after reset", vb, 1'b0);
    check_bit("dut4 data after reset", db, 1'b0);
    rst = 1'b0;
    tname = "idle";
    repeat (5) @(posedge clk);

    tname = "ones32";
    run_vec(rep("1", 32), {rep("111110", 6), "11"}, rep("111110", 6));
    wait_drain();

    do_reset();
    tname = "nostuff";
    run_vec("1111011110", "1111011110", "1111011110");
    wait_drain();

    do_reset();
    tname = "trailing_stuff";
    run_vec("0011111", "00111110", "00111110");
    wait_drain();

    do_reset();
    tname = "split_run";
`ifdef STUF_IDLE_CLEAR_EN
    exp5 = "110";
`else
    exp5 = "1100";
`endif
    run_vec("111", "111", "111");
    repeat (3) @(posedge clk);
    run_vec("110", exp5, exp5);
    wait_drain();

    // Reset asserted between edges while both DUTs are still draining.
    do_reset();
    tname = "reset_mid_drain";
    run_vec(rep("1", 32), {rep("111110", 6), "11"}, rep("111110", 6));
    @(posedge clk); #3;
    rst = 1'b1;
    qa.delete();
    qb.delete();
    #1;
    check_bit("dut16 valid during async reset", va, 1'b0);
    check_bit("dut16 data during async reset", da, 1'b0);
    check_bit("dut4 valid during async reset", vb, 1'b0);
    check_bit("dut4 data during async reset", db, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (30) @(posedge clk);

    // DEPTH=4 overflows: seven bits land on full stuff cycles and are dropped.
    tname = "ones64_overflow";
    run_vec(rep("1", 64), {rep("111110", 12), "1111"}, {rep("111110", 11), "11"});
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: simulation still running, required completion");
    $fatal(1, "timeout");
  end

endmodule
